// File: rtl/cipher_pkg.sv
// -----------------------------------------------------------------------------
// cipher_pkg
//
// Definitions shared by the cipher pipeline: the input loader, the encrypt
// stage and the future decrypt stage.
//
// Contents:
//   - Loader FSM state encoding (2 bits, plain constants so that older
//     blocks comparing raw state bits keep working).
//   - ASCII bounds for the legal alphabet and the lower-to-upper case offset.
//   - Small classification helpers for a single ASCII byte.
// -----------------------------------------------------------------------------
package cipher_pkg;

    typedef logic [1:0] cipher_state_t;

    // Loader FSM states
    localparam logic [1:0] S_SECRET = 2'd0;  // collecting key characters
    localparam logic [1:0] S_TEXT   = 2'd1;  // collecting message characters
    localparam logic [1:0] S_DONE   = 2'd2;  // both buffers full, waiting for ack
    localparam logic [1:0] S_ERR    = 2'd3;  // illegal character seen, waiting for ack

    // ASCII alphabet bounds
    localparam logic [7:0] ASCII_UPPER_FIRST = 8'h41;  // 'A'
    localparam logic [7:0] ASCII_UPPER_LAST  = 8'h5A;  // 'Z'
    localparam logic [7:0] ASCII_LOWER_FIRST = 8'h61;  // 'a'
    localparam logic [7:0] ASCII_LOWER_LAST  = 8'h7A;  // 'z'
    localparam logic [7:0] ASCII_CASE_FOLD   = 8'h20;  // 'a' - 'A'

    function automatic logic is_upper(input logic [7:0] ch);
        return (ch >= ASCII_UPPER_FIRST) && (ch <= ASCII_UPPER_LAST);
    endfunction

    function automatic logic is_lower(input logic [7:0] ch);
        return (ch >= ASCII_LOWER_FIRST) && (ch <= ASCII_LOWER_LAST);
    endfunction

endpackage

// File: rtl/cipher_char_normalize.sv
// -----------------------------------------------------------------------------
// cipher_char_normalize
//
// Purely combinational character filter. Upper-case letters pass through,
// lower-case letters are folded to upper case, every other byte is flagged
// illegal (the output character is then 0 and must not be used).
//
// Ports:
//   i_w_char     in   8  raw ASCII byte
//   o_w_char     out  8  upper-case letter (valid when o_w_illegal is 0)
//   o_w_illegal  out  1  byte is not a letter
// -----------------------------------------------------------------------------
module cipher_char_normalize
    import cipher_pkg::*;
(
    input  logic [7:0] i_w_char,
    output logic [7:0] o_w_char,
    output logic       o_w_illegal
);

    always_comb begin
        o_w_char    = 8'h00;
        o_w_illegal = 1'b1;
        if (is_upper(i_w_char)) begin
            o_w_char    = i_w_char;
            o_w_illegal = 1'b0;
        end else if (is_lower(i_w_char)) begin
            o_w_char    = i_w_char - ASCII_CASE_FOLD;
            o_w_illegal = 1'b0;
        end
    end

endmodule

// File: rtl/cipher_input_loader.sv
// -----------------------------------------------------------------------------
// cipher_input_loader
//
// Upstream feeder for the encrypt stage. Takes one ASCII character per cycle,
// fills the secret buffer first and the text buffer second, then holds both
// (o_r_done = 1) until the consumer acknowledges. Any non-letter stops the
// load and raises o_r_error until acknowledged.
//
// Handshake: a byte is transferred on a rising edge where i_w_valid and
// o_w_ready are both 1. o_w_ready depends on the FSM state only (never on
// i_w_valid); it is 1 while collecting and 0 in S_DONE / S_ERR, so bytes
// offered then are simply not taken. i_w_ack is only honoured in S_DONE and
// S_ERR.
//
// Ports:
//   i_w_clk     in   1       clock, rising edge
//   i_w_rst     in   1       synchronous active-high reset
//   i_w_valid   in   1       upstream byte valid
//   i_w_data    in   8       upstream ASCII byte
//   o_w_ready   out  1       loader can accept a byte this cycle
//   i_w_ack     in   1       consumer took the buffers / clears an error
//   o_r_secret  out  S*8     secret, first character in the MSB byte
//   o_r_text    out  M*8     text, first character in the MSB byte
//   o_r_done    out  1       both buffers complete and stable
//   o_r_error   out  1       illegal character received
//   o_r_state   out  2       current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module cipher_input_loader
    import cipher_pkg::*;
#(
    parameter int p_message_length = 27,
    parameter int p_secret_length  = 6
) (
    input  logic                          i_w_clk,
    input  logic                          i_w_rst,
    input  logic                          i_w_valid,
    input  logic [7:0]                    i_w_data,
    output logic                          o_w_ready,
    input  logic                          i_w_ack,
    output logic [p_secret_length*8-1:0]  o_r_secret,
    output logic [p_message_length*8-1:0] o_r_text,
    output logic                          o_r_done,
    output logic                          o_r_error,
    output logic [1:0]                    o_r_state
);

    localparam int MAX_LEN = (p_message_length > p_secret_length) ?
                             p_message_length : p_secret_length;
    // Guard the degenerate single-character case so the counter is never 0 bits.
    localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] SECRET_LAST = CW'(p_secret_length - 1);
    localparam logic [CW-1:0] TEXT_LAST   = CW'(p_message_length - 1);

    cipher_state_t state_q;
    logic [CW-1:0] counter_q;

    logic [7:0] norm_char;
    logic       norm_illegal;
    logic       xfer;

    cipher_char_normalize u_normalize (
        .i_w_char    (i_w_data),
        .o_w_char    (norm_char),
        .o_w_illegal (norm_illegal)
    );

    assign o_w_ready = (state_q == S_SECRET) || (state_q == S_TEXT);
    assign xfer      = i_w_valid && o_w_ready;
    assign o_r_state = state_q;

    always_ff @(posedge i_w_clk) begin
        if (i_w_rst) begin
            state_q    <= S_SECRET;
            counter_q  <= '0;
            o_r_secret <= '0;
            o_r_text   <= '0;
            o_r_done   <= 1'b0;
            o_r_error  <= 1'b0;
        end else begin
            case (state_q)
                S_SECRET: begin
                    if (xfer) begin
                        if (norm_illegal) begin
                            // Byte dropped, buffers left as they are.
                            state_q   <= S_ERR;
                            o_r_error <= 1'b1;
                        end else begin
                            // Character k lands in byte (L-1-k), i.e. string-literal order.
                            for (int i = 0; i < p_secret_length; i++) begin
                                if (counter_q == CW'(i)) begin
                                    o_r_secret[(p_secret_length-1-i)*8 +: 8] <= norm_char;
                                end
                            end
                            if (counter_q == SECRET_LAST) begin
                                counter_q <= '0;
                                state_q   <= S_TEXT;
                            end else begin
                                counter_q <= counter_q + CW'(1);
                            end
                        end
                    end
                end

                S_TEXT: begin
                    if (xfer) begin
                        if (norm_illegal) begin
                            state_q   <= S_ERR;
                            o_r_error <= 1'b1;
                        end else begin
                            for (int i = 0; i < p_message_length; i++) begin
                                if (counter_q == CW'(i)) begin
                                    o_r_text[(p_message_length-1-i)*8 +: 8] <= norm_char;
                                end
                            end
                            if (counter_q == TEXT_LAST) begin
                                // done rises on the edge that takes the last byte
                                state_q  <= S_DONE;
                                o_r_done <= 1'b1;
                            end else begin
                                counter_q <= counter_q + CW'(1);
                            end
                        end
                    end
                end

                S_DONE, S_ERR: begin
                    // Both exits return to the full reset picture.
                    if (i_w_ack) begin
                        state_q    <= S_SECRET;
                        counter_q  <= '0;
                        o_r_secret <= '0;
                        o_r_text   <= '0;
                        o_r_done   <= 1'b0;
                        o_r_error  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_SECRET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_input_loader.sv
module tb_cipher_input_loader;
    import cipher_pkg::*;

    logic         clk;
    logic         rst;
    logic         valid;
    logic [7:0]   data;
    logic         ready;
    logic         ack;
    logic [47:0]  secret;
    logic [215:0] text;
    logic         done;
    logic         error;
    logic [1:0]   state;

    int vectors;
    int miscompares;
    int cyc;

    logic [47:0]  secret_up;
    logic [47:0]  secret_lo;
    logic [215:0] text_up;
    logic [215:0] text_lo;

    cipher_input_loader #(
        .p_message_length (27),
        .p_secret_length  (6)
    ) dut (
        .i_w_clk    (clk),
        .i_w_rst    (rst),
        .i_w_valid  (valid),
        .i_w_data   (data),
        .o_w_ready  (ready),
        .i_w_ack    (ack),
        .o_r_secret (secret),
        .o_r_text   (text),
        .o_r_done   (done),
        .o_r_error  (error),
        .o_r_state  (state)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance one edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    // Feed bytes [first, first+count) of the 33-byte stream secret||text.
    // With gaps, each byte is preceded by a valid-low cycle carrying junk.
    task automatic feed(input logic [47:0] s, input logic [215:0] t,
                        input int first, input int count, input bit gaps);
        logic [7:0] b;
        for (int k = first; k < first + count; k++) begin
            if (k < 6) b = s[(5-k)*8 +: 8];
            else       b = t[(32-k)*8 +: 8];
            if (gaps) begin
                valid = 1'b0;
                data  = 8'h35;
                step();
            end
            vectors++;
            if (ready !== 1'b1) begin
                miscompares++;
                $display("FAIL feed_ready byte %0d: got %b want 1", k, ready);
            end
            if (k == 32) begin
                vectors++;
                if (done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_early: got %b want 0 before byte 33", done);
                end
            end
            valid = 1'b1;
            data  = b;
            step();
        end
        valid = 1'b0;
        data  = 8'h00;
    endtask

    // Check a completed load against expected buses.
    task automatic check_full(input string name, input logic [47:0] es, input logic [215:0] et);
        vectors++;
        if (secret !== es) begin
            miscompares++;
            $display("FAIL %s secret: got %h want %h", name, secret, es);
        end
        vectors++;
        if (text !== et) begin
            miscompares++;
            $display("FAIL %s text: got %h want %h", name, text, et);
        end
        vectors++;
        if (done !== 1'b1 || ready !== 1'b0 || state !== S_DONE) begin
            miscompares++;
            $display("FAIL %s done/ready/state: got %b/%b/%0d want 1/0/%0d", name, done, ready, state, S_DONE);
        end
    endtask

    // Check the all-clear picture seen after reset or ack.
    task automatic check_clear(input string name);
        vectors++;
        if (secret !== 48'h0 || text !== 216'h0) begin
            miscompares++;
            $display("FAIL %s buses: got %h / %h want 0", name, secret, text);
        end
        vectors++;
        if (done !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL %s flags: got done=%b err=%b want 0/0", name, done, error);
        end
        vectors++;
        if (ready !== 1'b1 || state !== S_SECRET) begin
            miscompares++;
            $display("FAIL %s ready/state: got %b/%0d want 1/%0d", name, ready, state, S_SECRET);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_clear("reset");
    endtask

    task automatic test_upper_load();
        feed(secret_up, text_up, 0, 5, 1'b0);
        vectors++;
        if (state !== S_SECRET) begin
            miscompares++;
            $display("FAIL state_after_5: got %0d want %0d", state, S_SECRET);
        end
        feed(secret_up, text_up, 5, 1, 1'b0);
        vectors++;
        if (state !== S_TEXT || secret !== secret_up) begin
            miscompares++;
            $display("FAIL secret_boundary: got st=%0d sec=%h want %0d/%h", state, secret, S_TEXT, secret_up);
        end
        feed(secret_up, text_up, 6, 27, 1'b0);
        check_full("upper", secret_up, text_up);
    endtask

    task automatic test_done_hold();
        logic [7:0] extra [5];
        extra = '{8'h51, 8'h52, 8'h35, 8'h61, 8'h5A};
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data  = extra[i];
            step();
            vectors++;
            if (secret !== secret_up || text !== text_up || ready !== 1'b0 || done !== 1'b1) begin
                miscompares++;
                $display("FAIL done_hold cyc %0d: got sec=%h rdy=%b done=%b want %h/0/1", i, secret, ready, done, secret_up);
            end
        end
        valid = 1'b0;
        do_ack();
        check_clear("done_ack");
    endtask

    task automatic test_lower_gaps();
        int start;
        start = cyc;
        feed(secret_lo, text_lo, 0, 33, 1'b1);
        vectors++;
        if (cyc - start !== 66) begin
            miscompares++;
            $display("FAIL gap_cycles: got %0d want 66", cyc - start);
        end
        check_full("lower_gaps", secret_up, text_up);
    endtask

    task automatic test_error_midsecret();
        feed(secret_up, text_up, 0, 2, 1'b0);
        valid = 1'b1;
        data  = 8'h35;
        step();
        valid = 1'b0;
        vectors++;
        if (error !== 1'b1 || ready !== 1'b0 || state !== S_ERR || done !== 1'b0) begin
            miscompares++;
            $display("FAIL err_flags: got err=%b rdy=%b st=%0d done=%b want 1/0/%0d/0", error, ready, state, S_ERR, done);
        end
        vectors++;
        if (secret !== 48'h4441_0000_0000) begin
            miscompares++;
            $display("FAIL err_secret: got %h want %h", secret, 48'h4441_0000_0000);
        end
        // Letters offered while in error are not taken.
        valid = 1'b1;
        data  = 8'h4E;
        step();
        step();
        valid = 1'b0;
        vectors++;
        if (secret !== 48'h4441_0000_0000 || state !== S_ERR) begin
            miscompares++;
            $display("FAIL err_hold: got sec=%h st=%0d want 444100000000/%0d", secret, state, S_ERR);
        end
        do_ack();
        check_clear("err_ack");
        feed(secret_up, text_up, 0, 33, 1'b0);
        check_full("after_err", secret_up, text_up);
        do_ack();
    endtask

    task automatic test_illegal_bounds();
        logic [7:0] bad [7];
        bad = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h00, 8'hFF, 8'h20};
        for (int i = 0; i < 7; i++) begin
            valid = 1'b1;
            data  = bad[i];
            step();
            valid = 1'b0;
            vectors++;
            if (error !== 1'b1 || secret !== 48'h0) begin
                miscompares++;
                $display("FAIL illegal_%h: got err=%b sec=%h want 1/0", bad[i], error, secret);
            end
            do_ack();
        end
        // Illegal byte in the text field: secret intact, first text bytes kept.
        feed(secret_up, text_up, 0, 9, 1'b0);
        valid = 1'b1;
        data  = 8'h7B;
        step();
        valid = 1'b0;
        vectors++;
        if (error !== 1'b1 || secret !== secret_up || text !== {24'h544558, 192'h0}) begin
            miscompares++;
            $display("FAIL illegal_text: got err=%b sec=%h txt=%h", error, secret, text);
        end
        do_ack();
    endtask

    task automatic test_legal_bounds();
        logic [47:0] s_mix;
        s_mix = "azAZmQ";
        feed(s_mix, text_lo, 0, 33, 1'b0);
        check_full("legal_bounds", 48'h415A_415A_4D51, text_up);
        do_ack();
    endtask

    task automatic test_reset_midload();
        feed(secret_up, text_up, 0, 10, 1'b0);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'h58;
        step();
        rst   = 1'b0;
        valid = 1'b0;
        check_clear("mid_reset");
        feed(secret_up, text_up, 0, 33, 1'b0);
        check_full("after_reset", secret_up, text_up);
        do_ack();
    endtask

    task automatic test_ack_in_text();
        feed(secret_up, text_up, 0, 8, 1'b0);
        do_ack();
        vectors++;
        if (state !== S_TEXT || secret !== secret_up || text !== {16'h5445, 200'h0}) begin
            miscompares++;
            $display("FAIL ack_in_text: got st=%0d sec=%h txt=%h", state, secret, text);
        end
        feed(secret_up, text_up, 8, 25, 1'b0);
        check_full("ack_in_text", secret_up, text_up);
        do_ack();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        ack   = 1'b0;
        secret_up = "DANILA";
        secret_lo = "danila";
        text_up   = "TEXTFOARTELUNGDEMULTELITERE";
        text_lo   = "textfoartelungdemultelitere";
        #1;

        test_reset();
        test_upper_load();
        test_done_hold();
        test_lower_gaps();
        do_ack();
        test_error_midsecret();
        test_illegal_bounds();
        test_legal_bounds();
        test_reset_midload();
        test_ack_in_text();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
